// File: rtl/ehl_ahb_pkg.sv
// Shared AHB encodings and widths for the matrix slices.
package ehl_ahb_pkg;
  localparam int AW = 32;
  localparam int DW = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [1:0] HRESP_OKAY  = 2'd0;
  localparam logic [1:0] HRESP_ERROR = 2'd1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          write;
    logic [2:0]    size;
    logic [2:0]    burst;
    logic [3:0]    prot;
  } ahb_ctrl_t;
endpackage

// File: rtl/ehl_ahb_rr_arbiter.sv
// Combinational arbiter: round-robin from last+1, or fixed lowest-index priority.
module ehl_ahb_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic          rr,
  output logic [IW-1:0] gnt,
  output logic          any
);
  always_comb begin
    int  idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    gnt   = '0;
    for (int i = 0; i < N; i++) begin
      idx = rr ? (int'(last) + 1 + i) % N : i;
      if (!found && req[idx]) begin
        gnt   = IW'(idx);
        found = 1'b1;
      end
    end
    any = |req;
  end
endmodule

// File: rtl/ehl_ahb_matrix_out.sv
// Per-slave output stage: arbitrates master address phases onto one slave,
// parks not-taken address phases in a per-master hold register, routes responses back.
module ehl_ahb_matrix_out
  import ehl_ahb_pkg::*;
#(
  parameter int MNUM   = 2,
  parameter bit ARB_RR = 1
) (
  input  logic                     hclk,
  input  logic                     hresetn,
  input  logic [MNUM-1:0][1:0]     im_htrans,
  input  logic [MNUM-1:0][AW-1:0]  im_haddr,
  input  logic [MNUM-1:0]          im_hwrite,
  input  logic [MNUM-1:0][2:0]     im_hsize,
  input  logic [MNUM-1:0][2:0]     im_hburst,
  input  logic [MNUM-1:0][3:0]     im_hprot,
  input  logic [MNUM-1:0][DW-1:0]  im_hwdata,
  input  logic [MNUM-1:0]          im_hready,
  output logic [MNUM-1:0]          om_hready,
  output logic [MNUM-1:0][1:0]     om_hresp,
  output logic [DW-1:0]            om_hrdata,
  output logic                     s_hsel,
  output logic [AW-1:0]            s_haddr,
  output logic [1:0]               s_htrans,
  output logic                     s_hwrite,
  output logic [2:0]               s_hsize,
  output logic [2:0]               s_hburst,
  output logic [3:0]               s_hprot,
  output logic [DW-1:0]            s_hwdata,
  output logic                     s_hready,
  input  logic                     s_hreadyout,
  input  logic [1:0]               s_hresp,
  input  logic [DW-1:0]            s_hrdata
);
  localparam int IW = (MNUM > 1) ? $clog2(MNUM) : 1;

  logic [MNUM-1:0] live_v, acc, req, hold_v;
  ahb_ctrl_t       hold_q [MNUM];
  logic [IW-1:0]   aowner, last_q, downer, g, arb_gnt;
  logic            dvalid, arb_any, lock;

  assign req = hold_v | live_v;

  ehl_ahb_rr_arbiter #(.N(MNUM), .IW(IW)) u_arb (
    .req  (req),
    .last (last_q),
    .rr   (ARB_RR),
    .gnt  (arb_gnt),
    .any  (arb_any)
  );

  // A burst in progress (SEQ/BUSY) from the current owner cannot be preempted.
  assign lock = (im_htrans[aowner] == HTRANS_SEQ) || (im_htrans[aowner] == HTRANS_BUSY);
  assign g    = lock ? aowner : (arb_any ? arb_gnt : aowner);

  genvar m;
  for (m = 0; m < MNUM; m++) begin : g_mst
    logic      hv;
    ahb_ctrl_t hq;
    logic      own, taken;

    assign live_v[m] = im_htrans[m][1] & im_hready[m];
    assign acc[m]    = (im_htrans[m] != HTRANS_IDLE) & im_hready[m];
    assign taken     = (g == IW'(m)) & s_hreadyout;

    always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
        hv <= 1'b0;
        hq <= '0;
      end else if (hv && taken) begin
        hv <= 1'b0;
      end else if (acc[m] && !taken) begin
        hv <= 1'b1;
        hq <= '{addr: im_haddr[m], write: im_hwrite[m], size: im_hsize[m],
                burst: im_hburst[m], prot: im_hprot[m]};
      end
    end

    assign hold_v[m] = hv;
    assign hold_q[m] = hq;

    // A parked master is stalled until its replay completes its data phase.
    assign own          = dvalid & (downer == IW'(m));
    assign om_hready[m] = own ? s_hreadyout : ~hv;
    assign om_hresp[m]  = own ? s_hresp : HRESP_OKAY;
  end

  always_comb begin
    s_htrans = HTRANS_IDLE;
    s_haddr  = im_haddr[g];
    s_hwrite = im_hwrite[g];
    s_hsize  = im_hsize[g];
    s_hburst = im_hburst[g];
    s_hprot  = im_hprot[g];
    if (hold_v[g]) begin
      s_htrans = HTRANS_NONSEQ;
      s_haddr  = hold_q[g].addr;
      s_hwrite = hold_q[g].write;
      s_hsize  = hold_q[g].size;
      s_hburst = hold_q[g].burst;
      s_hprot  = hold_q[g].prot;
    end else if (live_v[g]) begin
      s_htrans = im_htrans[g];
    end
  end

  assign s_hsel    = s_htrans[1];
  assign s_hready  = s_hreadyout;
  assign s_hwdata  = im_hwdata[downer];
  assign om_hrdata = s_hrdata;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      aowner <= '0;
      last_q <= IW'(MNUM - 1);
      downer <= '0;
      dvalid <= 1'b0;
    end else if (s_hreadyout) begin
      aowner <= g;
      downer <= g;
      dvalid <= s_htrans[1];
      if (s_htrans[1]) last_q <= g;
    end
  end
endmodule
